// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (IFU/LSU) arbiter onto a single non-pipelined memory port, with watchdog.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority with LSU first.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_rvalid,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wmask,
    output logic              lsu_rvalid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              timeout_err
);
    localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        wmask_q, wmask_d;
    logic [WW-1:0]     wdog_q, wdog_d;
    logic              err_q, err_d;
    logic              pick_lsu, busy, resp, abort, done;
    logic [DATA_W-1:0] resp_data;

`ifdef MEM_ARB_RR_EN
    // rr_q remembers the master granted last (0 = IFU); the other one is favoured next
    logic rr_q, rr_d;
    assign pick_lsu = lsu_req_valid && (!ifu_req_valid || !rr_q);
    assign rr_d     = (state_q == IDLE && (ifu_req_valid || lsu_req_valid)) ? pick_lsu : rr_q;
`else
    assign pick_lsu = lsu_req_valid;
`endif

    assign busy      = state_q != IDLE;
    assign resp      = state_q == WAIT && mem_rvalid;
    assign abort     = TIMEOUT > 0 && busy && !resp && wdog_q == WW'(TIMEOUT - 1);
    assign done      = resp || abort;
    assign resp_data = (resp && !wen_q) ? mem_rdata : '0;

    assign ifu_rvalid    = done && !owner_q;
    assign lsu_rvalid    = done && owner_q;
    assign ifu_rdata     = ifu_rvalid ? resp_data : '0;
    assign lsu_rdata     = lsu_rvalid ? resp_data : '0;
    assign mem_req_valid = state_q == REQ;
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign timeout_err   = err_q;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        wen_d         = wen_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        err_d         = err_q || abort;
        wdog_d        = (TIMEOUT > 0 && busy && !done) ? wdog_q + WW'(1) : '0;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        case (state_q)
            IDLE: if (ifu_req_valid || lsu_req_valid) begin
                ifu_req_ready = !pick_lsu;
                lsu_req_ready = pick_lsu;
                owner_d       = pick_lsu;
                addr_d        = pick_lsu ? lsu_addr : ifu_addr;
                wen_d         = pick_lsu && lsu_wen;
                wdata_d       = pick_lsu ? lsu_wdata : '0;
                wmask_d       = pick_lsu ? lsu_wmask : '0;
                state_d       = REQ;
            end
            REQ:     state_d = abort ? IDLE : (mem_req_ready ? WAIT : REQ);
            WAIT:    state_d = done ? IDLE : WAIT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            wdog_q  <= '0;
            err_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            rr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
`ifdef MEM_ARB_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end
endmodule
